// File: rtl/gcd_lcm_post.sv
// gcd_lcm_post: lcm = (a / g) * b using a restoring divider then shift-add multiplier.
// Optional build macro GCD_LCM_REM_CHECK_EN flags err when g does not divide a.
module gcd_lcm_post #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] lcm,
  output logic             out_valid,
  output logic             ovf,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   g_r;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH:0]     rem;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH+1:0]   diff;
  logic               ge;
  logic [WIDTH:0]     rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_nx;

  assign in_ready = (state == IDLE);

  // One restoring-divide step and one shift-add multiply step
  always_comb begin
    diff    = {rem, quo[WIDTH-1]} - {2'b00, g_r};
    ge      = ~diff[WIDTH+1];
    rem_nx  = ge ? diff[WIDTH:0] : {rem[WIDTH-1:0], quo[WIDTH-1]};
    quo_nx  = {quo[WIDTH-2:0], ge};
    sum     = {1'b0, prod[2*WIDTH-1:WIDTH]}
            + {1'b0, (prod[0] ? b_r : {WIDTH{1'b0}})};
    prod_nx = {sum, prod[WIDTH-1:1]};
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      b_r       <= '0;
      g_r       <= '0;
      quo       <= '0;
      rem       <= '0;
      prod      <= '0;
      lcm       <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            b_r  <= b;
            g_r  <= g;
            quo  <= a;
            rem  <= '0;
            prod <= '0;
            cnt  <= '0;
            if (g == '0) begin
              lcm   <= '0;
              ovf   <= 1'b0;
              err   <= 1'b1;
              state <= DONE;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt  <= '0;
            prod <= {{WIDTH{1'b0}}, quo_nx};
`ifdef GCD_LCM_REM_CHECK_EN
            if (rem_nx != '0) begin
              lcm   <= '0;
              ovf   <= 1'b0;
              err   <= 1'b1;
              state <= DONE;
            end else begin
              state <= MUL;
            end
`else
            state <= MUL;
`endif
          end
        end
        MUL: begin
          prod <= prod_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt   <= '0;
            lcm   <= prod_nx[WIDTH-1:0];
            ovf   <= |prod_nx[2*WIDTH-1:WIDTH];
            err   <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_lcm_post.sv
// tb_gcd_lcm_post: directed checks of gcd_lcm_post latency, results and flags.
// Expected values are hand-computed per vector.
module tb_gcd_lcm_post;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b, g;
  logic [31:0] lcm;
  logic        out_valid, ovf, err;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  gcd_lcm_post #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .g(g), .lcm(lcm), .out_valid(out_valid),
    .ovf(ovf), .err(err)
  );

  // Drive one triple (called #1 after an edge); report edges to out_valid.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_,
                       input logic [31:0] tg, input int junk_at,
                       output int lat, output logic busy_ok);
    in_valid = 1'b1; a = ta; b = tb_; g = tg;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    busy_ok = !in_ready;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        in_valid = 1'b0;
        break;
      end
      if (in_ready) busy_ok = 1'b0;
      if (n == junk_at) begin
        in_valid = 1'b1; a = 32'd7; b = 32'd5; g = 32'd1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; g = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (lcm !== 32'd0 || out_valid !== 1'b0 || ovf !== 1'b0 ||
        err !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: lcm=%h ov=%b ovf=%b err=%b rdy=%b want 0 0 0 0 1",
               lcm, out_valid, ovf, err, in_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat; logic busy_ok;
    do_op(32'd36, 32'd9, 32'd9, 10, lat, busy_ok);
    checks++;
    if (lat !== 65) begin
      fails++; $display("FAIL basic_latency: got %0d want 65", lat);
    end
    checks++;
    if (lcm !== 32'd36 || ovf !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: lcm=%0d ovf=%b err=%b want 36 0 0", lcm, ovf, err);
    end
    checks++;
    if (busy_ok !== 1'b1) begin
      fails++; $display("FAIL basic_busy_ready: in_ready seen high while busy, want low");
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || lcm !== 32'd36) begin
      fails++;
      $display("FAIL basic_hold: out_valid=%b lcm=%0d want 0 36", out_valid, lcm);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic busy_ok;
    do_op(32'd4, 32'd6, 32'd2, 0, lat, busy_ok);
    checks++;
    if (lat !== 65 || lcm !== 32'd12 || err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: lat=%0d lcm=%0d err=%b want 65 12 0", lat, lcm, err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_ready: in_ready=%b want 1", in_ready);
    end
    do_op(32'd21, 32'd6, 32'd3, 0, lat, busy_ok);
    checks++;
    if (lat !== 65 || lcm !== 32'd42 || ovf !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: lat=%0d lcm=%0d ovf=%b err=%b want 65 42 0 0",
               lat, lcm, ovf, err);
    end
  endtask

  task automatic test_zero;
    int lat; logic busy_ok;
    do_op(32'd0, 32'd0, 32'd0, 0, lat, busy_ok);
    checks++;
    if (lat !== 1 || err !== 1'b1 || lcm !== 32'd0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL div_by_zero: lat=%0d err=%b lcm=%0d ovf=%b want 1 1 0 0",
               lat, err, lcm, ovf);
    end
    do_op(32'd0, 32'd5, 32'd5, 0, lat, busy_ok);
    checks++;
    if (lat !== 65 || err !== 1'b0 || lcm !== 32'd0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL a_zero: lat=%0d err=%b lcm=%0d ovf=%b want 65 0 0 0",
               lat, err, lcm, ovf);
    end
  endtask

  task automatic test_overflow;
    int lat; logic busy_ok;
    do_op(32'h0001_0000, 32'h0001_0001, 32'd1, 0, lat, busy_ok);
    checks++;
    if (lat !== 65 || lcm !== 32'h0001_0000 || ovf !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL overflow: lat=%0d lcm=%h ovf=%b err=%b want 65 00010000 1 0",
               lat, lcm, ovf, err);
    end
  endtask

  task automatic test_reset_abort;
    int lat; logic busy_ok; logic seen;
    in_valid = 1'b1; a = 32'd36; b = 32'd9; g = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || lcm !== 32'd0 || ovf !== 1'b0 ||
        err !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_state: ov=%b lcm=%h ovf=%b err=%b rdy=%b want 0 0 0 0 1",
               out_valid, lcm, ovf, err, in_ready);
    end
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL abort_no_strobe: out_valid=1 seen want none");
    end
    do_op(32'd36, 32'd9, 32'd9, 0, lat, busy_ok);
    checks++;
    if (lat !== 65 || lcm !== 32'd36 || err !== 1'b0) begin
      fails++;
      $display("FAIL abort_restart: lat=%0d lcm=%0d err=%b want 65 36 0", lat, lcm, err);
    end
  endtask

  task automatic test_rem_check;
    int lat; logic busy_ok;
    do_op(32'd10, 32'd4, 32'd3, 0, lat, busy_ok);
`ifdef GCD_LCM_REM_CHECK_EN
    checks++;
    if (lat !== 33 || err !== 1'b1 || lcm !== 32'd0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL rem_check: lat=%0d err=%b lcm=%0d ovf=%b want 33 1 0 0",
               lat, err, lcm, ovf);
    end
`else
    checks++;
    if (lat !== 65 || err !== 1'b0 || lcm !== 32'd12 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL rem_ignored: lat=%0d err=%b lcm=%0d ovf=%b want 65 0 12 0",
               lat, err, lcm, ovf);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero();
    test_overflow();
    test_reset_abort();
    test_rem_check();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
